// File: rtl/ppi_bus_ctrl_if.sv
// CPU-side bus of the 8255A core: strobes and write data in, output-latch
// loads, control word, direction bits and read-path select out.
interface ppi_bus_ctrl_if;
   logic       CS_n;
   logic       WR_n;
   logic       RD_n;
   logic [1:0] A;
   logic [7:0] D;
   logic [7:0] Din;
   logic       PAOutLd;
   logic       PBOutLd;
   logic       PCOutLd;
   logic [7:0] CtrlWord;
   logic       PADir;
   logic       PBDir;
   logic       PCUDir;
   logic       PCLDir;
   logic       RdEn;
   logic [1:0] RdSel;

   modport slave (
      input  CS_n, WR_n, RD_n, A, D,
      output Din, PAOutLd, PBOutLd, PCOutLd, CtrlWord,
             PADir, PBDir, PCUDir, PCLDir, RdEn, RdSel
   );

   modport master (
      output CS_n, WR_n, RD_n, A, D,
      input  Din, PAOutLd, PBOutLd, PCOutLd, CtrlWord,
             PADir, PBDir, PCUDir, PCLDir, RdEn, RdSel
   );
endinterface

// File: rtl/ppi_bus_ctrl.sv
// 8255A bus interface: synchronises the CPU write strobe, holds the mode-0
// control word, drives port latch loads and executes port C bit set/reset.
module ppi_bus_ctrl #(
   parameter logic [7:0] CTRL_RST = 8'h9B
) (
   input  logic           clk,
   input  logic           reset,
   ppi_bus_ctrl_if.slave  bus
);

   logic       wr_s1_q, wr_s1_d;
   logic       wr_s2_q, wr_s2_d;
   logic [1:0] cap_a_q, cap_a_d;
   logic [7:0] cap_d_q, cap_d_d;
   logic       cap_v_q, cap_v_d;
   logic [7:0] ctrl_q, ctrl_d;
   logic [7:0] pc_shadow_q, pc_shadow_d;
   logic [7:0] din_q, din_d;
   logic       pa_ld_q, pa_ld_d;
   logic       pb_ld_q, pb_ld_d;
   logic       pc_ld_q, pc_ld_d;
   logic       wr_rise;
   logic [7:0] bsr_img;

   always_comb begin
      wr_s1_d     = bus.WR_n;
      wr_s2_d     = wr_s1_q;
      cap_a_d     = cap_a_q;
      cap_d_d     = cap_d_q;
      cap_v_d     = cap_v_q;
      ctrl_d      = ctrl_q;
      pc_shadow_d = pc_shadow_q;
      din_d       = din_q;
      pa_ld_d     = 1'b1;
      pb_ld_d     = 1'b1;
      pc_ld_d     = 1'b1;
      wr_rise     = wr_s1_q & ~wr_s2_q;
      bsr_img     = pc_shadow_q;
      bsr_img[cap_d_q[3:1]] = cap_d_q[0];

      // Keep resampling while the strobe is low so the final sample wins.
      if (!wr_s1_q && !bus.CS_n) begin
         cap_a_d = bus.A;
         cap_d_d = bus.D;
         cap_v_d = 1'b1;
      end

      if (wr_rise && cap_v_q) begin
         cap_v_d = 1'b0;
         case (cap_a_q)
            2'b00: begin
               if (!ctrl_q[4]) begin
                  din_d   = cap_d_q;
                  pa_ld_d = 1'b0;
               end
            end
            2'b01: begin
               if (!ctrl_q[1]) begin
                  din_d   = cap_d_q;
                  pb_ld_d = 1'b0;
               end
            end
            2'b10: begin
               if (!ctrl_q[3] || !ctrl_q[0]) begin
                  pc_shadow_d = cap_d_q;
                  din_d       = cap_d_q;
                  pc_ld_d     = 1'b0;
               end
            end
            default: begin
               if (cap_d_q[7]) begin
                  // Only mode 0 exists, so the mode fields are forced to zero.
                  ctrl_d      = {1'b1, 2'b00, cap_d_q[4:3], 1'b0, cap_d_q[1:0]};
                  pc_shadow_d = 8'h00;
                  din_d       = 8'h00;
                  pa_ld_d     = 1'b0;
                  pb_ld_d     = 1'b0;
                  pc_ld_d     = 1'b0;
               end else begin
                  pc_shadow_d = bsr_img;
                  din_d       = bsr_img;
                  pc_ld_d     = 1'b0;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_s1_q     <= 1'b1;
         wr_s2_q     <= 1'b1;
         cap_a_q     <= 2'b00;
         cap_d_q     <= 8'h00;
         cap_v_q     <= 1'b0;
         ctrl_q      <= CTRL_RST;
         pc_shadow_q <= 8'h00;
         din_q       <= 8'h00;
         pa_ld_q     <= 1'b1;
         pb_ld_q     <= 1'b1;
         pc_ld_q     <= 1'b1;
      end else begin
         wr_s1_q     <= wr_s1_d;
         wr_s2_q     <= wr_s2_d;
         cap_a_q     <= cap_a_d;
         cap_d_q     <= cap_d_d;
         cap_v_q     <= cap_v_d;
         ctrl_q      <= ctrl_d;
         pc_shadow_q <= pc_shadow_d;
         din_q       <= din_d;
         pa_ld_q     <= pa_ld_d;
         pb_ld_q     <= pb_ld_d;
         pc_ld_q     <= pc_ld_d;
      end
   end

   assign bus.Din      = din_q;
   assign bus.PAOutLd  = pa_ld_q;
   assign bus.PBOutLd  = pb_ld_q;
   assign bus.PCOutLd  = pc_ld_q;
   assign bus.CtrlWord = ctrl_q;
   assign bus.PADir    = ctrl_q[4];
   assign bus.PBDir    = ctrl_q[1];
   assign bus.PCUDir   = ctrl_q[3];
   assign bus.PCLDir   = ctrl_q[0];
   assign bus.RdEn     = ~bus.CS_n & ~bus.RD_n & bus.WR_n & (bus.A != 2'b11);
   assign bus.RdSel    = bus.A;

endmodule

// File: tb/tb_ppi_bus_ctrl.sv
// Scoreboard bench for ppi_bus_ctrl: writes push expected load pulses,
// a monitor pops them when the DUT pulses a latch load.
module tb_ppi_bus_ctrl;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   int   cyc   = 0;
   int   n_checks = 0;
   int   n_fail   = 0;

   ppi_bus_ctrl_if bus ();

   ppi_bus_ctrl #(.CTRL_RST(8'h9B)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         cyc;
      logic [7:0] din;
      logic [2:0] ld;
      logic [7:0] ctrl;
   } exp_t;

   exp_t exp_q[$];

   // Reference state of the 8255 as the CPU sees it.
   logic [7:0] ctrl_m = 8'h9B;
   logic [7:0] pc_m   = 8'h00;
   logic [7:0] din_m  = 8'h00;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      ctrl_m = 8'h9B;
      pc_m   = 8'h00;
      din_m  = 8'h00;
   endtask

   task automatic model_write(input bit cs_low, input logic [1:0] a, input logic [7:0] d,
                              output bit pulse, output logic [2:0] ld);
      int n;
      pulse = 1'b0;
      ld    = 3'b111;
      if (!cs_low) return;
      case (a)
         2'd0: if (ctrl_m[4] == 1'b0) begin din_m = d; pulse = 1'b1; ld = 3'b011; end
         2'd1: if (ctrl_m[1] == 1'b0) begin din_m = d; pulse = 1'b1; ld = 3'b101; end
         2'd2: if (ctrl_m[3] == 1'b0 || ctrl_m[0] == 1'b0) begin
            pc_m = d; din_m = d; pulse = 1'b1; ld = 3'b110;
         end
         default: begin
            pulse = 1'b1;
            if (d[7]) begin
               ctrl_m = 8'h80 | (d & 8'h1B);
               pc_m   = 8'h00;
               din_m  = 8'h00;
               ld     = 3'b000;
            end else begin
               n = int'(d[3:1]);
               if (d[0]) pc_m = pc_m | (8'd1 << n);
               else      pc_m = pc_m & ~(8'd1 << n);
               din_m = pc_m;
               ld    = 3'b110;
            end
         end
      endcase
   endtask

   task automatic push_expect(input logic [2:0] ld, input int at);
      exp_t e;
      e.cyc  = at;
      e.din  = din_m;
      e.ld   = ld;
      e.ctrl = ctrl_m;
      exp_q.push_back(e);
   endtask

   task automatic check_state(input string tag);
      chk({tag, "_din"},  {24'd0, bus.Din},      {24'd0, din_m});
      chk({tag, "_ctrl"}, {24'd0, bus.CtrlWord}, {24'd0, ctrl_m});
      chk({tag, "_dirs"}, {28'd0, bus.PADir, bus.PBDir, bus.PCUDir, bus.PCLDir},
          {28'd0, ctrl_m[4], ctrl_m[1], ctrl_m[3], ctrl_m[0]});
   endtask

   task automatic do_write(input bit cs_low, input logic [1:0] a, input logic [7:0] d,
                           input int lo, input bit rd_too);
      bit         pulse;
      logic [2:0] ld;
      @(negedge clk);
      bus.CS_n = ~cs_low;
      bus.A    = a;
      bus.D    = d;
      bus.WR_n = 1'b0;
      bus.RD_n = ~rd_too;
      #1 chk("rden_while_wr_low", {31'd0, bus.RdEn}, 32'd0);
      repeat (lo) @(negedge clk);
      bus.WR_n = 1'b1;
      model_write(cs_low, a, d, pulse, ld);
      if (pulse) push_expect(ld, cyc + 2);
      repeat (2) @(negedge clk);
      bus.CS_n = 1'b1;
      bus.RD_n = 1'b1;
      repeat (2) @(negedge clk);
      $display("write cs=%0b A=%0d D=%02h pulse=%0b ld=%03b -> Din=%02h Ctrl=%02h",
               cs_low, a, d, pulse, ld, bus.Din, bus.CtrlWord);
      check_state("post_write");
   endtask

   task automatic do_read(input bit cs_n, input bit rd_n, input logic [1:0] a);
      @(negedge clk);
      bus.WR_n = 1'b1;
      bus.CS_n = cs_n;
      bus.RD_n = rd_n;
      bus.A    = a;
      #1;
      $display("read cs_n=%0b rd_n=%0b A=%0d -> RdEn=%0b RdSel=%0d", cs_n, rd_n, a, bus.RdEn, bus.RdSel);
      chk("rd_en",  {31'd0, bus.RdEn}, {31'd0, (cs_n == 1'b0 && rd_n == 1'b0 && a != 2'd3)});
      chk("rd_sel", {30'd0, bus.RdSel}, {30'd0, a});
      bus.CS_n = 1'b1;
      bus.RD_n = 1'b1;
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_ctrl"}, {24'd0, bus.CtrlWord}, 32'h9B);
      chk({tag, "_din"},  {24'd0, bus.Din}, 32'h00);
      chk({tag, "_ld"},   {29'd0, bus.PAOutLd, bus.PBOutLd, bus.PCOutLd}, 32'h7);
      chk({tag, "_dirs"}, {28'd0, bus.PADir, bus.PBDir, bus.PCUDir, bus.PCLDir}, 32'hF);
   endtask

   // Monitor: every latch-load pulse must match the head of the scoreboard.
   initial begin
      exp_t       e;
      logic [2:0] ld_now;
      bit         prev_low;
      prev_low = 1'b0;
      forever begin
         @(negedge clk);
         ld_now = {bus.PAOutLd, bus.PBOutLd, bus.PCOutLd};
         if (reset) begin
            prev_low = 1'b0;
         end else if (ld_now != 3'b111) begin
            chk("ld_two_cycles_low", {31'd0, prev_low}, 32'd0);
            if (exp_q.size() == 0) begin
               chk("unexpected_pulse", {29'd0, ld_now}, 32'h7);
            end else begin
               e = exp_q.pop_front();
               $display("pulse ld=%03b Din=%02h Ctrl=%02h at cycle %0d", ld_now, bus.Din, bus.CtrlWord, cyc);
               chk("pulse_cycle", cyc, e.cyc);
               chk("pulse_ld",    {29'd0, ld_now}, {29'd0, e.ld});
               chk("pulse_din",   {24'd0, bus.Din}, {24'd0, e.din});
               chk("pulse_ctrl",  {24'd0, bus.CtrlWord}, {24'd0, e.ctrl});
            end
            prev_low = 1'b1;
         end else begin
            prev_low = 1'b0;
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
               e = exp_q.pop_front();
               chk("missed_pulse", {29'd0, ld_now}, {29'd0, e.ld});
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      bus.CS_n = 1'b1;
      bus.WR_n = 1'b1;
      bus.RD_n = 1'b1;
      bus.A    = 2'b00;
      bus.D    = 8'h00;
      #1 reset = 1'b1;
      #1 check_reset_values("reset");
      repeat (3) @(negedge clk);
      reset = 1'b0;
      model_reset();

      do_write(1, 2'd3, 8'h80, 2, 0);
      do_write(1, 2'd1, 8'hA5, 2, 0);
      do_write(1, 2'd3, 8'h82, 3, 0);
      do_write(1, 2'd1, 8'h3C, 2, 1);
      do_write(1, 2'd3, 8'h80, 2, 0);
      do_write(1, 2'd2, 8'h00, 2, 0);
      do_write(1, 2'd3, 8'h0B, 2, 0);
      do_write(1, 2'd3, 8'h01, 4, 0);
      do_write(0, 2'd1, 8'hFF, 2, 0);
      do_write(1, 2'd3, 8'hE7, 2, 0);
      do_write(1, 2'd3, 8'h80, 2, 0);

      // Reset during a port B write: the captured write must be discarded.
      @(negedge clk);
      bus.CS_n = 1'b0; bus.A = 2'd1; bus.D = 8'h55; bus.WR_n = 1'b0;
      repeat (2) @(negedge clk);
      #2 reset = 1'b1;
      #1 check_reset_values("async_reset");
      @(negedge clk);
      bus.WR_n = 1'b1;
      bus.CS_n = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      model_reset();
      repeat (4) @(negedge clk);
      $display("reset mid-write -> Din=%02h Ctrl=%02h", bus.Din, bus.CtrlWord);
      check_reset_values("mid_write_reset");

      // Reset released while WR_n is still low with CS_n low: fresh samples commit.
      begin
         bit         pulse;
         logic [2:0] ld;
         @(negedge clk);
         bus.CS_n = 1'b0; bus.A = 2'd3; bus.D = 8'h98; bus.WR_n = 1'b0;
         repeat (2) @(negedge clk);
         reset = 1'b1;
         @(negedge clk);
         reset = 1'b0;
         model_reset();
         repeat (3) @(negedge clk);
         bus.WR_n = 1'b1;
         model_write(1, 2'd3, 8'h98, pulse, ld);
         push_expect(ld, cyc + 2);
         repeat (2) @(negedge clk);
         bus.CS_n = 1'b1;
         repeat (2) @(negedge clk);
         $display("write after reset release -> Din=%02h Ctrl=%02h", bus.Din, bus.CtrlWord);
         check_state("post_release");
      end

      for (int i = 0; i < 80; i++) begin
         logic [1:0] a;
         logic [7:0] d;
         a = 2'($urandom_range(0, 3));
         d = 8'($urandom);
         do_write($urandom_range(0, 9) != 0, a, d, int'($urandom_range(2, 4)), $urandom_range(0, 3) == 0);
         if ($urandom_range(0, 3) == 0)
            do_read(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
      end
      do_read(0, 0, 2'd3);
      do_read(0, 0, 2'd2);

      repeat (5) @(negedge clk);
      chk("scoreboard_empty", exp_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
